// File: rtl/tour_pkg.sv
// Shared constants, state encoding and move table for the tour player.
// Move table packs one 3-bit two's-complement step per move bit.
package tour_pkg;

  localparam int NUM_MOVES = 24;

  localparam logic [7:0] RESP_MID  = 8'h5A;
  localparam logic [7:0] RESP_DONE = 8'hA5;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;
  localparam logic [7:0] WEST  = 8'h3F;

  localparam logic [3:0] OP_MOVE         = 4'h4;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h5;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } play_state_t;

  // bit7 .. bit0
  localparam logic [23:0] DX_TAB = {
    3'b010, 3'b010, 3'b001, 3'b111,
    3'b110, 3'b110, 3'b111, 3'b001
  };
  localparam logic [23:0] DY_TAB = {
    3'b001, 3'b111, 3'b110, 3'b110,
    3'b111, 3'b001, 3'b010, 3'b010
  };

  function automatic logic [3:0] mag3(input logic [2:0] v);
    logic [2:0] n;
    n = v[2] ? (~v + 3'd1) : v;
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/tour_move_decode.sv
// One-hot move to signed (dx,dy); lowest set bit wins, zero maps to bit0.
// legal flags an exactly-one-hot move.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic              [7:0] move,
  output logic signed       [2:0] dx,
  output logic signed       [2:0] dy,
  output logic                    legal
);

  logic [2:0] sel;
  logic [4:0] base;

  // lowest set bit selects the table entry
  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (move[i]) sel = 3'(i);
    end
  end

  assign base  = 5'(sel) * 5'd3;
  assign dx    = DX_TAB[base +: 3];
  assign dy    = DY_TAB[base +: 3];
  assign legal = $onehot(move);

endmodule

// File: rtl/tour_cmd_player.sv
// Plays a stored knight's tour as vertical/horizontal drive commands.
// Optional TOUR_CMD_ILLEGAL_CHK_EN adds the sticky illegal-move check.
module tour_cmd_player
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  output logic [4:0]  mv_indx,
  input  logic [7:0]  move,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_err
);

  play_state_t state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;

  logic signed [2:0] dx, dy;
  logic              mv_legal;
  logic [15:0]       vcmd, hcmd;
  logic              last;
  logic              ill;

  tour_move_decode u_dec (
    .move  (move),
    .dx    (dx),
    .dy    (dy),
    .legal (mv_legal)
  );

  assign vcmd = {OP_MOVE, dy[2] ? SOUTH : NORTH, mag3(dy)};
  assign hcmd = {OP_MOVE_FANFARE, dx[2] ? WEST : EAST, mag3(dx)};
  assign last = (mv_indx_q == 5'(NUM_MOVES - 1));
  assign mv_indx = mv_indx_q;

`ifdef TOUR_CMD_ILLEGAL_CHK_EN
  logic tour_err_q, tour_err_d;

  assign ill = ~mv_legal;

  // sticky error: set on a bad move in VERT, cleared by a new tour
  always_comb begin
    tour_err_d = tour_err_q;
    if (state_q == IDLE && start_tour) tour_err_d = 1'b0;
    else if (state_q == VERT && ill) tour_err_d = 1'b1;
  end

  // error flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tour_err_q <= 1'b0;
    else        tour_err_q <= tour_err_d;
  end

  assign tour_err = tour_err_q;
`else
  logic unused_legal;

  assign unused_legal = mv_legal;
  assign ill          = 1'b0;
  assign tour_err     = 1'b0;
`endif

  // next state, move index and output mux
  always_comb begin
    state_d   = state_q;
    mv_indx_d = mv_indx_q;
    cmd       = vcmd;
    cmd_rdy   = 1'b0;
    resp      = RESP_MID;
    unique case (state_q)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_DONE;
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = '0;
        end
      end
      VERT: begin
        if (ill) begin
          state_d = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = WAIT_V;
        end
      end
      WAIT_V: begin
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = hcmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd = hcmd;
        if (last) resp = RESP_DONE;
        if (send_resp) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and move index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

endmodule
